// File: rtl/main_memory_line_controller_if.sv
// Line-transfer bundle between the last-level cache (master) and the main memory controller (slave).
// Requests use valid/ready; read beats and write beats are unthrottled streams.
interface main_memory_line_controller_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
);
   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic                  mem_req_write;
   logic [ADDR_WIDTH-1:0] mem_req_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_wdata_valid;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_rdata_valid;
   logic                  mem_rdata_last;
   logic                  mem_done;
   logic                  mem_busy;

   modport master (
      output mem_req_valid, mem_req_write, mem_req_addr, mem_wdata, mem_wdata_valid,
      input  mem_req_ready, mem_rdata, mem_rdata_valid, mem_rdata_last, mem_done, mem_busy
   );

   modport slave (
      input  mem_req_valid, mem_req_write, mem_req_addr, mem_wdata, mem_wdata_valid,
      output mem_req_ready, mem_rdata, mem_rdata_valid, mem_rdata_last, mem_done, mem_busy
   );
endinterface

// File: rtl/main_memory_line_controller.sv
// Main memory array serving whole-line bursts; reads start READ_LATENCY idle cycles after accept,
// done follows the last write beat by WRITE_LATENCY+1; one transfer at a time, write beats may stall.
module main_memory_line_controller #(
   parameter int ADDR_WIDTH     = 16,
   parameter int DATA_WIDTH     = 32,
   parameter int DEPTH          = 1024,
   parameter int WORDS_PER_LINE = 4,
   parameter int READ_LATENCY   = 3,
   parameter int WRITE_LATENCY  = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   main_memory_line_controller_if.slave  bus
);
   localparam int IDX_W   = $clog2(DEPTH);
   localparam int BEAT_W  = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
   localparam int LAT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   localparam int LAT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
   localparam logic [IDX_W-1:0]  LINE_MASK = ~IDX_W'(WORDS_PER_LINE - 1);
   localparam logic [LAT_W-1:0]  RD_LAT_M1 = LAT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
   localparam logic [LAT_W-1:0]  WR_LAT_M1 = LAT_W'((WRITE_LATENCY > 0) ? WRITE_LATENCY - 1 : 0);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_RD_WAIT  = 3'd1;
   localparam logic [2:0] S_RD_BURST = 3'd2;
   localparam logic [2:0] S_WR_BURST = 3'd3;
   localparam logic [2:0] S_WR_WAIT  = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [2:0]            state_q, state_d;
   logic [IDX_W-1:0]      base_q, base_d;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic [LAT_W-1:0]      lat_q, lat_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rvld_q, rvld_d;
   logic                  rlast_q, rlast_d;

   logic [ADDR_WIDTH-1:0] req_addr;
   logic [IDX_W-1:0]      req_idx;
   logic [IDX_W-1:0]      rd_idx;
   logic [IDX_W-1:0]      wr_idx;
   logic                  rd_fetch;
   logic                  wr_en;

   // Line-aligned base, folded into the array; aligned bases never straddle the top of the array.
   assign req_addr = bus.mem_req_addr;
   assign req_idx  = IDX_W'(req_addr) & LINE_MASK;
   assign wr_idx   = base_q + IDX_W'(beat_q);

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      beat_d   = beat_q;
      lat_d    = lat_q;
      rdata_d  = rdata_q;
      rd_fetch = 1'b0;
      rd_idx   = base_q + IDX_W'(beat_q);
      wr_en    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.mem_req_valid) begin
               base_d = req_idx;
               beat_d = '0;
               if (bus.mem_req_write) begin
                  state_d = S_WR_BURST;
               end else if (READ_LATENCY == 0) begin
                  state_d  = S_RD_BURST;
                  rd_fetch = 1'b1;
                  rd_idx   = req_idx;
               end else begin
                  state_d = S_RD_WAIT;
                  lat_d   = RD_LAT_M1;
               end
            end
         end
         S_RD_WAIT: begin
            if (lat_q == '0) begin
               state_d  = S_RD_BURST;
               rd_fetch = 1'b1;
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         S_RD_BURST: begin
            // The registered beat leaves one cycle after its fetch, so fetch one beat ahead.
            if (beat_q == LAST_BEAT) begin
               state_d = S_DONE;
               beat_d  = '0;
            end else begin
               beat_d   = beat_q + BEAT_W'(1);
               rd_fetch = 1'b1;
               rd_idx   = base_q + IDX_W'(beat_d);
            end
         end
         S_WR_BURST: begin
            if (bus.mem_wdata_valid) begin
               wr_en = 1'b1;
               if (beat_q == LAST_BEAT) begin
                  beat_d = '0;
                  if (WRITE_LATENCY == 0) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_WR_WAIT;
                     lat_d   = WR_LAT_M1;
                  end
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         S_WR_WAIT: begin
            if (lat_q == '0) begin
               state_d = S_DONE;
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      rvld_d  = rd_fetch;
      rlast_d = rd_fetch && (beat_d == LAST_BEAT);
      if (rd_fetch) begin
         rdata_d = mem_q[rd_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         beat_q  <= '0;
         lat_q   <= '0;
         rdata_q <= '0;
         rvld_q  <= 1'b0;
         rlast_q <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         beat_q  <= beat_d;
         lat_q   <= lat_d;
         rdata_q <= rdata_d;
         rvld_q  <= rvld_d;
         rlast_q <= rlast_d;
      end
   end

   // Reset wins over a beat presented on the same edge; the array itself is never cleared.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) begin
         mem_q[wr_idx] <= bus.mem_wdata;
      end
   end

   assign bus.mem_req_ready   = (state_q == S_IDLE);
   assign bus.mem_busy        = (state_q != S_IDLE);
   assign bus.mem_done        = (state_q == S_DONE);
   assign bus.mem_rdata       = rdata_q;
   assign bus.mem_rdata_valid = rvld_q;
   assign bus.mem_rdata_last  = rlast_q;
endmodule

// File: tb/tb_main_memory_line_controller.sv
// Two controllers (default parameters, and an 8-word single-line array with zero latencies) checked
// every cycle against per-cycle expectations derived from the transfer timing rules and a word-array model.
module tb_main_memory_line_controller;
   localparam int NC = 1024;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   main_memory_line_controller_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus0 ();
   main_memory_line_controller_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus1 ();

   main_memory_line_controller #(
      .ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(1024), .WORDS_PER_LINE(4),
      .READ_LATENCY(3), .WRITE_LATENCY(2)
   ) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

   main_memory_line_controller #(
      .ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(8), .WORDS_PER_LINE(8),
      .READ_LATENCY(0), .WRITE_LATENCY(0)
   ) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

   int p_rl  [2] = '{3, 0};
   int p_wl  [2] = '{2, 0};
   int p_w   [2] = '{4, 8};
   int p_dep [2] = '{1024, 8};

   // Expectations are indexed by the number of the clock edge that opens the cycle.
   logic [31:0] mdl       [2][1024];
   bit          exp_busy  [2][NC];
   bit          exp_rvld  [2][NC];
   bit          exp_last  [2][NC];
   bit          exp_done  [2][NC];
   logic [31:0] exp_rdata [2][NC];

   int g = 0;
   int errors = 0;
   int checks = 0;
   int ndone [2] = '{0, 0};
   bit chk_en = 1'b0;

   always @(posedge clk) g <= g + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   function automatic logic get_ready(int d);
      return (d == 0) ? bus0.mem_req_ready : bus1.mem_req_ready;
   endfunction
   function automatic logic get_busy(int d);
      return (d == 0) ? bus0.mem_busy : bus1.mem_busy;
   endfunction
   function automatic logic get_rvld(int d);
      return (d == 0) ? bus0.mem_rdata_valid : bus1.mem_rdata_valid;
   endfunction
   function automatic logic get_last(int d);
      return (d == 0) ? bus0.mem_rdata_last : bus1.mem_rdata_last;
   endfunction
   function automatic logic get_done(int d);
      return (d == 0) ? bus0.mem_done : bus1.mem_done;
   endfunction
   function automatic logic [31:0] get_rdata(int d);
      return (d == 0) ? bus0.mem_rdata : bus1.mem_rdata;
   endfunction

   function automatic int line_base(int d, logic [15:0] a);
      return (int'(a) & ~(p_w[d] - 1)) % p_dep[d];
   endfunction

   always @(negedge clk) begin
      if (chk_en && g < NC) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d ready e%0d", d, g), get_ready(d), !exp_busy[d][g]);
            chk($sformatf("d%0d busy e%0d", d, g), get_busy(d), exp_busy[d][g]);
            chk($sformatf("d%0d rvalid e%0d", d, g), get_rvld(d), exp_rvld[d][g]);
            chk($sformatf("d%0d rlast e%0d", d, g), get_last(d), exp_last[d][g]);
            chk($sformatf("d%0d done e%0d", d, g), get_done(d), exp_done[d][g]);
            if (exp_rvld[d][g])
               chk($sformatf("d%0d rdata e%0d", d, g), get_rdata(d), exp_rdata[d][g]);
            if (get_done(d)) ndone[d]++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input int d, input logic v, input logic w, input logic [15:0] a);
      if (d == 0) begin
         bus0.mem_req_valid = v; bus0.mem_req_write = w; bus0.mem_req_addr = a;
      end else begin
         bus1.mem_req_valid = v; bus1.mem_req_write = w; bus1.mem_req_addr = a;
      end
   endtask

   task automatic drive_wr(input int d, input logic wv, input logic [31:0] wd);
      if (d == 0) begin
         bus0.mem_wdata_valid = wv; bus0.mem_wdata = wd;
      end else begin
         bus1.mem_wdata_valid = wv; bus1.mem_wdata = wd;
      end
   endtask

   // Read accepted at edge gh: beat i in relative cycle RL+1+i, done in RL+W+1.
   task automatic fill_read(input int d, input int gh, input int base);
      for (int i = 0; i < p_w[d]; i++) begin
         exp_rvld[d][gh + p_rl[d] + i]  = 1'b1;
         exp_rdata[d][gh + p_rl[d] + i] = mdl[d][(base + i) % p_dep[d]];
         exp_last[d][gh + p_rl[d] + i]  = (i == p_w[d] - 1);
      end
      exp_done[d][gh + p_rl[d] + p_w[d]] = 1'b1;
      for (int c = 0; c <= p_rl[d] + p_w[d]; c++) exp_busy[d][gh + c] = 1'b1;
   endtask

   // pat holds the wdata_valid sequence from cycle 1, leftmost bit first; beat data is dbase+beat.
   task automatic do_write(input int d, input logic [15:0] addr, input logic [31:0] dbase,
                           input logic [15:0] pat, input int plen, output int done_obs);
      int base, k, nb, gh, dn, bi;
      bit pv;
      base = line_base(d, addr);
      nb = 0;
      k = 0;
      for (int c = 1; c <= plen; c++) begin
         if (pat[plen - c] && nb < p_w[d]) begin
            nb++;
            if (nb == p_w[d]) k = c;
         end
      end
      dn = k + p_wl[d] + 1;
      drive_req(d, 1'b1, 1'b1, addr);
      step();
      gh = g;
      drive_req(d, 1'b0, 1'b0, 16'h0);
      for (int c = 1; c <= dn; c++) exp_busy[d][gh + c - 1] = 1'b1;
      exp_done[d][gh + dn - 1] = 1'b1;
      for (int i = 0; i < p_w[d]; i++) mdl[d][(base + i) % p_dep[d]] = dbase + 32'(i);
      done_obs = -1;
      bi = 0;
      for (int c = 1; c <= dn; c++) begin
         if (get_done(d)) done_obs = c;
         pv = (c <= plen) ? pat[plen - c] : 1'b0;
         if (pv && bi < p_w[d]) begin
            drive_wr(d, 1'b1, dbase + 32'(bi));
            bi++;
         end else begin
            drive_wr(d, 1'b0, 32'hDEAD_BEEF);
         end
         step();
      end
      drive_wr(d, 1'b0, 32'h0);
   endtask

   task automatic do_read(input int d, input logic [15:0] addr, output logic [31:0] beats [8],
                          output int nbeats, output int done_obs);
      int gh, dn;
      drive_req(d, 1'b1, 1'b0, addr);
      step();
      gh = g;
      drive_req(d, 1'b0, 1'b0, 16'h0);
      fill_read(d, gh, line_base(d, addr));
      dn = p_rl[d] + p_w[d] + 1;
      nbeats = 0;
      done_obs = -1;
      for (int i = 0; i < 8; i++) beats[i] = 32'h0;
      for (int c = 1; c <= dn; c++) begin
         if (get_rvld(d) && nbeats < 8) begin
            beats[nbeats] = get_rdata(d);
            nbeats++;
         end
         if (get_done(d)) done_obs = c;
         step();
      end
   endtask

   initial begin
      logic [31:0] rb [8];
      int nb, dob, gh, g2, nd0;

      for (int d = 0; d < 2; d++) begin
         drive_req(d, 1'b0, 1'b0, 16'h0);
         drive_wr(d, 1'b0, 32'h0);
      end
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("d%0d reset ready", d), get_ready(d), 1'b1);
         chk($sformatf("d%0d reset rdata", d), get_rdata(d), 32'h0);
         chk($sformatf("d%0d reset done", d), get_done(d), 1'b0);
      end
      chk_en = 1'b1;

      // Plain write then read of the same line.
      do_write(0, 16'h0040, 32'hA0, 16'b1111, 4, dob);
      chk("wr0 done cycle", dob, 7);
      chk("wr0 ready cycle 8", get_ready(0), 1'b1);
      do_read(0, 16'h0042, rb, nb, dob);
      chk("rd0 beat count", nb, 4);
      for (int i = 0; i < 4; i++) chk($sformatf("rd0 beat%0d", i), rb[i], 32'hA0 + 32'(i));
      chk("rd0 done cycle", dob, 8);

      // Write beats with gaps.
      do_write(0, 16'h0080, 32'hB0, 16'b1001101, 7, dob);
      chk("wr gaps done cycle", dob, 10);
      do_read(0, 16'h0081, rb, nb, dob);
      for (int i = 0; i < 4; i++) chk($sformatf("rd gaps beat%0d", i), rb[i], 32'hB0 + 32'(i));

      // Address above the array folds onto words 0x3FC-0x3FF.
      do_write(0, 16'h07FC, 32'hC0, 16'b1111, 4, dob);
      do_read(0, 16'h03FD, rb, nb, dob);
      for (int i = 0; i < 4; i++) chk($sformatf("rd wrap beat%0d", i), rb[i], 32'hC0 + 32'(i));

      // Reset in cycle 2 of a write, after one beat.
      drive_req(0, 1'b1, 1'b1, 16'h0041);
      step();
      gh = g;
      drive_req(0, 1'b0, 1'b0, 16'h0);
      exp_busy[0][gh]     = 1'b1;
      exp_busy[0][gh + 1] = 1'b1;
      mdl[0][16'h40] = 32'hD0;
      drive_wr(0, 1'b1, 32'hD0);
      step();
      drive_wr(0, 1'b0, 32'h0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("ready after mid reset", get_ready(0), 1'b1);
      do_read(0, 16'h0040, rb, nb, dob);
      chk("rd after reset beat0", rb[0], 32'hD0);
      for (int i = 1; i < 4; i++) chk($sformatf("rd after reset beat%0d", i), rb[i], 32'hA0 + 32'(i));

      // Request held high through a read burst: accepted again only once idle.
      nd0 = ndone[0];
      drive_req(0, 1'b1, 1'b0, 16'h0080);
      step();
      gh = g;
      g2 = gh + p_rl[0] + p_w[0] + 2;
      fill_read(0, gh, 16'h80);
      fill_read(0, g2, 16'h80);
      while (g < g2) step();
      drive_req(0, 1'b0, 1'b0, 16'h0);
      while (g < g2 + p_rl[0] + p_w[0] + 1) step();
      chk("held request done pulses", ndone[0] - nd0, 2);

      // Single-line array, zero latencies.
      do_write(1, 16'h0005, 32'hE0, 16'b11111111, 8, dob);
      chk("small wr done cycle", dob, 9);
      do_read(1, 16'h0003, rb, nb, dob);
      chk("small rd beat count", nb, 8);
      for (int i = 0; i < 8; i++) chk($sformatf("small rd beat%0d", i), rb[i], 32'hE0 + 32'(i));
      chk("small rd done cycle", dob, 9);

      repeat (3) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
